// File: rtl/ip_codma_mem_responder_if.sv
// rtl/ip_codma_mem_responder_if.sv - codma memory bus between a master and the memory responder
// Signal names keep the responder's point of view (_i driven by master, _o driven by responder).
interface ip_codma_mem_responder_if;
  logic        read_i;
  logic        write_i;
  logic [31:0] addr_i;
  logic [7:0]  size_i;
  logic        write_valid_i;
  logic [63:0] write_data_i;
  logic        grant_o;
  logic        read_valid_o;
  logic [63:0] read_data_o;
  logic        error_o;
  logic        busy_o;

  modport master (
    output read_i, write_i, addr_i, size_i, write_valid_i, write_data_i,
    input  grant_o, read_valid_o, read_data_o, error_o, busy_o
  );

  modport slave (
    input  read_i, write_i, addr_i, size_i, write_valid_i, write_data_i,
    output grant_o, read_valid_o, read_data_o, error_o, busy_o
  );
endinterface

// File: rtl/ip_codma_mem_responder.sv
// rtl/ip_codma_mem_responder.sv - codma bus responder backed by a word-addressed memory array
// Requests are range-checked at capture; beats move two 32-bit words, low word at the lower address.
module ip_codma_mem_responder #(
  parameter int DEPTH_WORDS   = 256,
  parameter int GRANT_LATENCY = 2,
  parameter int WR_TIMEOUT    = 16
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  ip_codma_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = AW + 1;
  localparam logic [15:0] GL_LAST = 16'((GRANT_LATENCY > 0) ? GRANT_LATENCY - 1 : 0);
  localparam logic [15:0] TO_LAST = 16'((WR_TIMEOUT > 0) ? WR_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GRANT,
    RD_DATA,
    WR_DATA,
    ERR
  } state_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  state_t      r_state;
  logic        r_is_read;
  logic [IW-1:0] r_idx;
  logic [3:0]  r_beats;
  logic [15:0] r_wait;
  logic [15:0] r_stall;
  logic        r_grant;
  logic        r_rvalid;
  logic [63:0] r_rdata;
  logic        r_error;

  logic          w_req;
  logic [32:0]   w_end;
  logic          w_req_ok;
  logic [AW-1:0] w_idx_lo;
  logic [AW-1:0] w_idx_hi;
  logic [63:0]   w_rd_beat;
  logic          w_beat_acc;
  logic          w_mem_we;

  assign w_req = bus.read_i | bus.write_i;

  // End word index is formed 33 bits wide so a huge address cannot wrap into range.
  assign w_end    = {3'b000, bus.addr_i[31:2]} + {25'd0, bus.size_i};
  assign w_req_ok = (bus.addr_i[1:0] == 2'b00) &&
                    (bus.size_i != 8'd0) &&
                    !bus.size_i[0] &&
                    (bus.size_i <= 8'd16) &&
                    (w_end <= 33'(DEPTH_WORDS));

  assign w_idx_lo  = r_idx[AW-1:0];
  assign w_idx_hi  = w_idx_lo + AW'(1);
  assign w_rd_beat = {r_mem[w_idx_hi], r_mem[w_idx_lo]};

  assign w_beat_acc = (r_state == WR_DATA) && bus.write_valid_i;
  assign w_mem_we   = w_beat_acc && !r_idx[IW-1];

  assign bus.grant_o      = r_grant;
  assign bus.read_valid_o = r_rvalid;
  assign bus.read_data_o  = r_rdata;
  assign bus.error_o      = r_error;
  assign bus.busy_o       = (r_state != IDLE);

  // Array contents survive reset, so the storage has no reset term.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[w_idx_lo] <= bus.write_data_i[31:0];
      r_mem[w_idx_hi] <= bus.write_data_i[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= IDLE;
      r_is_read <= 1'b0;
      r_idx     <= '0;
      r_beats   <= '0;
      r_wait    <= '0;
      r_stall   <= '0;
      r_grant   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
    end else begin
      r_grant <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_read <= bus.read_i;
            r_idx     <= bus.addr_i[IW+1:2];
            r_beats   <= bus.size_i[4:1];
            r_wait    <= '0;
            r_stall   <= '0;
            if (!w_req_ok) begin
              r_state <= ERR;
              r_error <= 1'b1;
            end else if (GRANT_LATENCY == 0) begin
              r_state <= GRANT;
              r_grant <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (r_wait == GL_LAST) begin
            r_state <= GRANT;
            r_grant <= 1'b1;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        // The first read beat is fetched here so it is valid in the cycle after the grant.
        GRANT: begin
          if (r_is_read) begin
            r_state  <= RD_DATA;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_beat;
            r_idx    <= r_idx + IW'(2);
            r_beats  <= r_beats - 4'd1;
          end else begin
            r_state <= WR_DATA;
          end
        end

        RD_DATA: begin
          if (r_beats == 4'd0) begin
            r_state  <= IDLE;
            r_rvalid <= 1'b0;
          end else begin
            r_rdata <= w_rd_beat;
            r_idx   <= r_idx + IW'(2);
            r_beats <= r_beats - 4'd1;
          end
        end

        WR_DATA: begin
          if (bus.write_valid_i) begin
            r_idx   <= r_idx + IW'(2);
            r_stall <= '0;
            if (r_beats == 4'd1) begin
              r_state <= IDLE;
            end else begin
              r_beats <= r_beats - 4'd1;
            end
          end else if (r_stall == TO_LAST) begin
            r_state <= ERR;
            r_error <= 1'b1;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end

        ERR: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// tb/tb_ip_codma_mem_responder.sv - directed bench for the codma memory responder
// dut0 runs GRANT_LATENCY=2, dut1 runs GRANT_LATENCY=0; both share clock and reset.
module tb_ip_codma_mem_responder;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  ip_codma_mem_responder_if bus0();
  ip_codma_mem_responder_if bus1();

  ip_codma_mem_responder #(.DEPTH_WORDS(256), .GRANT_LATENCY(2), .WR_TIMEOUT(16)) dut0 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus0)
  );

  ip_codma_mem_responder #(.DEPTH_WORDS(256), .GRANT_LATENCY(0), .WR_TIMEOUT(16)) dut1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [256];

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Raise a request on bus0, wait (bounded) for grant_o, then drop the request and scramble addr/size.
  task automatic req0(input logic rd, input logic wr, input logic [31:0] a, input logic [7:0] s,
                      input int exp_lat, input string tag);
    int lat;
    lat = 0;
    bus0.read_i  = rd;
    bus0.write_i = wr;
    bus0.addr_i  = a;
    bus0.size_i  = s;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus0.grant_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus0.read_i  = 1'b0;
    bus0.write_i = 1'b0;
    bus0.addr_i  = 32'hFFFF_FFFF;
    bus0.size_i  = 8'hFF;
    check64({tag, "_grant_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic wr_beat(input int widx, input logic [63:0] d);
    bus0.write_valid_i = 1'b1;
    bus0.write_data_i  = d;
    tick();
    bus0.write_valid_i = 1'b0;
    bus0.write_data_i  = 64'hBADB_ADBA_DBAD_BADB;
    model[widx]   = d[31:0];
    model[widx+1] = d[63:32];
  endtask

  task automatic read_check(input logic [31:0] a, input int s, input string tag);
    int w;
    logic [63:0] last;
    w = int'(a >> 2);
    last = '0;
    req0(1'b1, 1'b0, a, 8'(s), 3, tag);
    for (int b = 0; b < s / 2; b++) begin
      tick();
      last = {model[w + 2*b + 1], model[w + 2*b]};
      check1({tag, "_valid"}, bus0.read_valid_o, 1'b1);
      check64({tag, "_data"}, bus0.read_data_o, last);
    end
    tick();
    check1({tag, "_valid_end"}, bus0.read_valid_o, 1'b0);
    check1({tag, "_busy_end"}, bus0.busy_o, 1'b0);
    check64({tag, "_data_hold"}, bus0.read_data_o, last);
  endtask

  task automatic invalid_req(input logic [31:0] a, input logic [7:0] s, input string tag);
    int noise;
    noise = 0;
    bus0.write_i = 1'b1;
    bus0.addr_i  = a;
    bus0.size_i  = s;
    tick();
    check1({tag, "_error"}, bus0.error_o, 1'b1);
    check1({tag, "_busy_err"}, bus0.busy_o, 1'b1);
    check1({tag, "_no_grant"}, bus0.grant_o, 1'b0);
    bus0.write_i = 1'b0;
    tick();
    check1({tag, "_error_once"}, bus0.error_o, 1'b0);
    check1({tag, "_idle"}, bus0.busy_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus0.grant_o !== 1'b0 || bus0.error_o !== 1'b0 || bus0.read_valid_o !== 1'b0) noise++;
    end
    check64({tag, "_quiet"}, 64'(noise), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    bus0.read_i = 1'b0; bus0.write_i = 1'b0; bus0.addr_i = '0; bus0.size_i = '0;
    bus0.write_valid_i = 1'b0; bus0.write_data_i = '0;
    bus1.read_i = 1'b0; bus1.write_i = 1'b0; bus1.addr_i = '0; bus1.size_i = '0;
    bus1.write_valid_i = 1'b0; bus1.write_data_i = '0;

    tick();
    tick();
    check1("rst_busy", bus0.busy_o, 1'b0);
    check1("rst_grant", bus0.grant_o, 1'b0);
    check1("rst_error", bus0.error_o, 1'b0);
    check1("rst_rvalid", bus0.read_valid_o, 1'b0);
    check64("rst_rdata", bus0.read_data_o, 64'd0);
    reset_n_i = 1'b1;
    tick();

    // Known contents for words 0..7.
    req0(1'b0, 1'b1, 32'h0, 8'd8, 3, "fill0");
    tick();
    wr_beat(0, 64'hA000_0001_A000_0000);
    wr_beat(2, 64'hA000_0003_A000_0002);
    wr_beat(4, 64'hA000_0005_A000_0004);
    wr_beat(6, 64'hA000_0007_A000_0006);
    check1("fill0_busy_end", bus0.busy_o, 1'b0);

    req0(1'b0, 1'b1, 32'h40, 8'd4, 3, "wr40");
    tick();
    wr_beat(16, 64'h2222_2222_1111_1111);
    check1("wr40_busy_mid", bus0.busy_o, 1'b1);
    wr_beat(18, 64'h4444_4444_3333_3333);
    check1("wr40_busy_end", bus0.busy_o, 1'b0);
    read_check(32'h40, 4, "rd40");

    invalid_req(32'h42, 8'd2, "misalign");
    invalid_req(32'h40, 8'd3, "odd");
    invalid_req(32'h40, 8'd18, "big");
    invalid_req(32'h3F8, 8'd4, "range");
    read_check(32'h40, 4, "rd40_again");

    // Last four words of the array: exactly in range.
    req0(1'b0, 1'b1, 32'h3F0, 8'd4, 3, "top_wr");
    tick();
    wr_beat(252, 64'hF000_00FD_F000_00FC);
    wr_beat(254, 64'hF000_00FF_F000_00FE);
    read_check(32'h3F0, 4, "top_rd");

    // Read wins over write; write_valid_i during the read is ignored.
    req0(1'b1, 1'b1, 32'h0, 8'd2, 3, "both");
    bus0.write_valid_i = 1'b1;
    bus0.write_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    check1("both_valid", bus0.read_valid_o, 1'b1);
    check64("both_data", bus0.read_data_o, 64'hA000_0001_A000_0000);
    bus0.write_valid_i = 1'b0;
    tick();
    check1("both_valid_end", bus0.read_valid_o, 1'b0);

    req0(1'b0, 1'b1, 32'h80, 8'd4, 3, "stall");
    tick();
    repeat (3) tick();
    wr_beat(32, 64'h5A5A_0021_5A5A_0020);
    repeat (3) tick();
    wr_beat(34, 64'h5A5A_0023_5A5A_0022);
    check1("stall_busy_end", bus0.busy_o, 1'b0);
    read_check(32'h80, 4, "stall_rd");

    req0(1'b0, 1'b1, 32'hC0, 8'd4, 3, "pre_c0");
    tick();
    wr_beat(48, 64'h0C0C_0C01_0C0C_0C00);
    wr_beat(50, 64'h0C0C_0C03_0C0C_0C02);
    req0(1'b0, 1'b1, 32'hC0, 8'd4, 3, "tmo");
    tick();
    wr_beat(48, 64'h6666_6666_5555_5555);
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus0.error_o !== 1'b0) early++;
    end
    check64("tmo_no_early_err", 64'(early), 64'd0);
    tick();
    check1("tmo_error", bus0.error_o, 1'b1);
    check1("tmo_busy_err", bus0.busy_o, 1'b1);
    tick();
    check1("tmo_error_once", bus0.error_o, 1'b0);
    check1("tmo_idle", bus0.busy_o, 1'b0);
    read_check(32'hC0, 4, "tmo_rd");

    // Asynchronous reset in the middle of the second read beat.
    req0(1'b1, 1'b0, 32'h0, 8'd8, 3, "rstrd");
    tick();
    check64("rstrd_b0", bus0.read_data_o, 64'hA000_0001_A000_0000);
    tick();
    check1("rstrd_b1_valid", bus0.read_valid_o, 1'b1);
    check64("rstrd_b1", bus0.read_data_o, 64'hA000_0003_A000_0002);
    #2;
    reset_n_i = 1'b0;
    #1;
    check1("arst_rvalid", bus0.read_valid_o, 1'b0);
    check1("arst_busy", bus0.busy_o, 1'b0);
    check1("arst_grant", bus0.grant_o, 1'b0);
    check1("arst_error", bus0.error_o, 1'b0);
    check64("arst_rdata", bus0.read_data_o, 64'd0);
    tick();
    reset_n_i = 1'b1;
    tick();
    read_check(32'h0, 8, "post_rst");

    // Zero grant latency on dut1.
    bus1.write_i = 1'b1; bus1.addr_i = 32'h10; bus1.size_i = 8'd2;
    tick();
    check1("gl0_wr_grant", bus1.grant_o, 1'b1);
    bus1.write_i = 1'b0;
    tick();
    bus1.write_valid_i = 1'b1;
    bus1.write_data_i  = 64'h7777_7777_8888_8888;
    tick();
    bus1.write_valid_i = 1'b0;
    check1("gl0_wr_busy_end", bus1.busy_o, 1'b0);
    bus1.read_i = 1'b1; bus1.addr_i = 32'h10; bus1.size_i = 8'd2;
    tick();
    check1("gl0_rd_grant", bus1.grant_o, 1'b1);
    check1("gl0_rd_novalid", bus1.read_valid_o, 1'b0);
    bus1.read_i = 1'b0;
    tick();
    check1("gl0_rd_valid", bus1.read_valid_o, 1'b1);
    check64("gl0_rd_data", bus1.read_data_o, 64'h7777_7777_8888_8888);
    tick();
    check1("gl0_rd_valid_end", bus1.read_valid_o, 1'b0);
    check1("gl0_rd_busy_end", bus1.busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_codma_mem_responder.md
Name: ip_codma_mem_responder

Overview:
- Slave/responder end of the codma memory bus: accepts read and write requests from the bus master, grants them, and serves or absorbs data beats.
- Backed by an internal word-addressed memory array.
- Used as the bus endpoint in codma simulation and as a synthesizable scratch memory on the system bus.
- Beats carry two 32-bit words, low word at the lower address.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).
- GRANT_LATENCY, 2, idle cycles between request capture and grant_o pulse (0 allowed).
- WR_TIMEOUT, 16, consecutive write-stall cycles before a write is aborted with error.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset.
- read_i  in  1  master read request.
- write_i  in  1  master write request.
- addr_i  in  32  byte address of first word.
- size_i  in  8  transfer length in 32-bit words.
- write_valid_i  in  1  write beat valid.
- write_data_i  in  64  write beat: [31:0] word n, [63:32] word n+1.
- grant_o  out  1  one-cycle grant pulse.
- read_valid_o  out  1  read beat valid.
- read_data_o  out  64  read beat, same packing as write_data_i.
- error_o  out  1  one-cycle error pulse.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (reset_n_i); clk_i is the only clock.
  - While reset is low, all outputs are 0 and the state is IDLE.
  - Array contents are not reset.
  - Reset mid-operation aborts immediately; words already written remain.
- States: IDLE, WAIT, GRANT, RD_DATA, WR_DATA, ERR.
- IDLE:
  - Samples read_i/write_i each cycle; if both are high, read wins.
  - On a request, addr_i and size_i are latched and checked; all later changes on those inputs are ignored.
  - Request is valid only if all hold: addr_i[1:0]==0; size_i nonzero and even; size_i<=16; (addr_i>>2)+size_i<=DEPTH_WORDS.
  - Valid request -> WAIT; invalid -> ERR.
- ERR: error_o=1 for exactly one cycle, then IDLE. No grant_o and no data beats.
- WAIT:
  - Counts GRANT_LATENCY cycles, then -> GRANT.
  - With GRANT_LATENCY=0, WAIT is skipped and GRANT is the cycle after capture.
- GRANT: grant_o=1 for exactly one cycle, then RD_DATA or WR_DATA. Beat counter = size/2; word index = addr>>2.
- RD_DATA:
  - First beat is the cycle after grant_o.
  - Every cycle: read_valid_o=1, read_data_o={mem[idx+1],mem[idx]}, idx+=2.
  - No backpressure; beats are back-to-back.
  - After the last beat -> IDLE, read_valid_o=0 the next cycle.
  - read_data_o holds its last value when not valid.
- WR_DATA:
  - A beat is accepted on any cycle with write_valid_i=1: mem[idx]<=write_data_i[31:0], mem[idx+1]<=write_data_i[63:32], idx+=2.
  - After size/2 accepted beats -> IDLE.
  - Cycles with write_valid_i=0 are stalls. WR_TIMEOUT consecutive stalls -> ERR; already-written words remain.
  - write_valid_i in any other state is ignored.
- Request levels:
  - read_i/write_i may drop after grant_o without effect.
  - Requests arriving while busy_o=1 are ignored, not queued.
  - A level still high on return to IDLE is captured as a new request.
- busy_o=1 in every state except IDLE, including ERR.
- Index arithmetic: width clog2(DEPTH_WORDS)+1. The range check guarantees no wrap.

Test Plan:
- Write then read, aligned: GRANT_LATENCY=2. Write addr=0x40, size=4, beats 0x22222222_11111111 and 0x44444444_33333333 -> grant_o 3 cycles after capture, busy_o low after beat 2. Then read addr=0x40, size=4 -> two consecutive read_valid_o beats with the same data, read_valid_o=0 after.
- Invalid requests each give exactly one error_o pulse, no grant_o, no array change:
  - addr=0x42 (misaligned);
  - size=3 (odd);
  - size=18 (>16);
  - addr=(DEPTH_WORDS-2)*4 with size=4 (out of range).
- Simultaneous read_i and write_i at addr=0x0, size=2 -> read served (read_valid_o beat), array unchanged.
- Write with stalls: size=4, write_valid_i gaps of 3 cycles -> both beats stored. Separately, 16 idle cycles after the first beat -> error_o pulse, word 0/1 updated, words 2/3 unchanged.
- Mid-read reset: assert reset_n_i during the second read beat of size=8 -> all outputs 0 asynchronously, busy_o=0. A subsequent read returns the previously stored data.
- GRANT_LATENCY=0: read size=2 -> grant_o the cycle after capture, data beat the following cycle.
